// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the IF stage.
// Registered fetch with freeze/flush, run-time loader and clear-on-reset.
module inst_mem_sync #(
   parameter int                DATA_W         = 32,
   parameter int                DEPTH          = 64,
   parameter int                PC_W           = 32,
   parameter logic [DATA_W-1:0] NOP_WORD       = '0,
   parameter bit                CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic [PC_W-1:0]   pc_in,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [PC_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] instruction,
   output logic [PC_W-1:0]   pc_out,
   output logic              inst_valid,
   output logic              addr_err,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [PC_W-1:0] LIMIT = PC_W'(DEPTH * 4);

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

   state_t state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     f_idx, ld_idx, wa;
   logic              f_in_range, f_mis;
   logic              ld_ok, bypass, we;
   logic [DATA_W-1:0] wd;

   assign f_idx      = pc_in[AW+1:2];
   assign f_in_range = pc_in < LIMIT;
   assign f_mis      = pc_in[1:0] != 2'b00;

   assign ld_idx = ld_addr[AW+1:2];
   assign ld_ok  = ld_valid && ld_ready && (ld_addr < LIMIT)
                && (ld_addr[1:0] == 2'b00);
   assign bypass = ld_ok && (ld_idx == f_idx);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy     = 1'b0;
      ld_ready = 1'b0;
      unique case (state_q)
         S_CLEAR: begin
            busy  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1))
               state_d = S_RUN;
         end
         S_RUN: begin
            ld_ready = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Single write port shared by clear sequence and loader.
   always_comb begin
      we = 1'b0;
      wa = '0;
      wd = '0;
      if (state_q == S_CLEAR) begin
         we = 1'b1;
         wa = cnt_q;
         wd = NOP_WORD;
      end else if (ld_ok) begin
         we = 1'b1;
         wa = ld_idx;
         wd = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instruction <= NOP_WORD;
         pc_out      <= '0;
         inst_valid  <= 1'b0;
         addr_err    <= 1'b0;
      end else if (state_q == S_RUN) begin
         if (flush) begin
            instruction <= NOP_WORD;
            pc_out      <= pc_in;
            inst_valid  <= 1'b0;
            addr_err    <= 1'b0;
         end else if (!freeze) begin
            pc_out     <= pc_in;
            inst_valid <= 1'b1;
            if (f_in_range) begin
               // Array read sees the old word; forward the new one.
               instruction <= bypass ? ld_data : mem[f_idx];
               addr_err    <= f_mis;
            end else begin
               instruction <= NOP_WORD;
               addr_err    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync: clear timing, table of fetch/load
// vectors, and reset restart in mid-clear.
module tb_inst_mem_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, flush, ld_valid;
   logic [31:0] pc_in, ld_addr, ld_data;

   logic        ld_ready, inst_valid, addr_err, busy;
   logic [31:0] instruction, pc_out;

   logic        ld_ready0, inst_valid0, addr_err0, busy0;
   logic [31:0] instruction0, pc_out0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_mem_sync #(
      .DATA_W(32), .DEPTH(64), .PC_W(32),
      .NOP_WORD(32'd0), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .pc_in(pc_in), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data),
      .instruction(instruction), .pc_out(pc_out),
      .inst_valid(inst_valid), .addr_err(addr_err), .busy(busy)
   );

   inst_mem_sync #(
      .DATA_W(32), .DEPTH(64), .PC_W(32),
      .NOP_WORD(32'd0), .CLEAR_ON_RESET(1'b0)
   ) dut0 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .pc_in(pc_in), .ld_valid(ld_valid), .ld_ready(ld_ready0),
      .ld_addr(ld_addr), .ld_data(ld_data),
      .instruction(instruction0), .pc_out(pc_out0),
      .inst_valid(inst_valid0), .addr_err(addr_err0), .busy(busy0)
   );

   typedef struct {
      logic        ld_v;
      logic [31:0] ld_a;
      logic [31:0] ld_d;
      logic        frz;
      logic        fls;
      logic [31:0] pc;
      logic [31:0] e_ins;
      logic [31:0] e_pc;
      logic        e_val;
      logic        e_err;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      freeze   = 1'b0;
      flush    = 1'b0;
      ld_valid = 1'b0;
      ld_addr  = 32'h0;
      ld_data  = 32'h0;
   endtask

   // Counts cycles with busy high, starting from the reset edge.
   task automatic count_clear(input string name);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (ld_ready !== 1'b0)
            chk({name, "_ld_ready_in_clear"}, {31'd0, ld_ready}, 32'd0);
         step();
      end
      chk({name, "_busy_cycles"}, n, 32'd64);
      chk({name, "_valid_after_clear"}, {31'd0, inst_valid}, 32'd0);
      chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
      chk({name, "_ld_ready_run"}, {31'd0, ld_ready}, 32'd1);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h10,
                   32'h0,        32'h10,  1'b1, 1'b0};
      vecs[1]  = '{1'b1, 32'h0,   32'hE3A00014, 1'b0, 1'b0, 32'h20,
                   32'h0,        32'h20,  1'b1, 1'b0};
      vecs[2]  = '{1'b1, 32'h4,   32'hE3A01A01, 1'b0, 1'b0, 32'h0,
                   32'hE3A00014, 32'h0,   1'b1, 1'b0};
      vecs[3]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h4,
                   32'hE3A01A01, 32'h4,   1'b1, 1'b0};
      vecs[4]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h4,
                   32'hE3A01A01, 32'h4,   1'b1, 1'b0};
      vecs[5]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h8,
                   32'hE3A01A01, 32'h4,   1'b1, 1'b0};
      vecs[6]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'hC,
                   32'hE3A01A01, 32'h4,   1'b1, 1'b0};
      vecs[7]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h10,
                   32'h0,        32'h10,  1'b0, 1'b0};
      vecs[8]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h100,
                   32'h0,        32'h100, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h6,
                   32'hE3A01A01, 32'h6,   1'b1, 1'b1};
      vecs[10] = '{1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,
                   32'hE3A00014, 32'h0,   1'b1, 1'b0};
      vecs[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,
                   32'hE3A00014, 32'h0,   1'b1, 1'b0};
      vecs[12] = '{1'b1, 32'h8,   32'hE0843002, 1'b0, 1'b0, 32'h8,
                   32'hE0843002, 32'h8,   1'b1, 1'b0};
      vecs[13] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h8,
                   32'hE0843002, 32'h8,   1'b1, 1'b0};
      vecs[14] = '{1'b1, 32'h6,   32'h11111111, 1'b0, 1'b0, 32'h4,
                   32'hE3A01A01, 32'h4,   1'b1, 1'b0};
      vecs[15] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h4,
                   32'hE3A01A01, 32'h4,   1'b1, 1'b0};
      vecs[16] = '{1'b1, 32'hC,   32'h12345678, 1'b0, 1'b1, 32'hC,
                   32'h0,        32'hC,   1'b0, 1'b0};
      vecs[17] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hC,
                   32'h12345678, 32'hC,   1'b1, 1'b0};
      vecs[18] = '{1'b1, 32'h10,  32'hAAAA5555, 1'b1, 1'b0, 32'h10,
                   32'h12345678, 32'hC,   1'b1, 1'b0};
      vecs[19] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h10,
                   32'hAAAA5555, 32'h10,  1'b1, 1'b0};

      idle();
      pc_in = 32'h0;
      rst   = 1'b1;
      step();
      chk("rst_instruction", instruction, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("noclr_busy", {31'd0, busy0}, 32'd0);
      chk("noclr_ld_ready", {31'd0, ld_ready0}, 32'd1);

      // Inputs active during clear must be ignored.
      rst      = 1'b0;
      pc_in    = 32'h10;
      ld_valid = 1'b1;
      ld_addr  = 32'h10;
      ld_data  = 32'hFFFFFFFF;
      count_clear("clr1");
      idle();

      for (int i = 0; i < NV; i++) begin
         ld_valid = vecs[i].ld_v;
         ld_addr  = vecs[i].ld_a;
         ld_data  = vecs[i].ld_d;
         freeze   = vecs[i].frz;
         flush    = vecs[i].fls;
         pc_in    = vecs[i].pc;
         chk($sformatf("v%0d_ld_ready", i), {31'd0, ld_ready}, 32'd1);
         step();
         chk($sformatf("v%0d_instruction", i), instruction,
             vecs[i].e_ins);
         chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].e_pc);
         chk($sformatf("v%0d_inst_valid", i), {31'd0, inst_valid},
             {31'd0, vecs[i].e_val});
         chk($sformatf("v%0d_addr_err", i), {31'd0, addr_err},
             {31'd0, vecs[i].e_err});
      end
      idle();

      // Reset again, then once more 20 cycles into the clear.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 19; i++) step();
      chk("midclr_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step();
      chk("midclr_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("noclr2_busy", {31'd0, busy0}, 32'd0);
      chk("noclr2_ld_ready", {31'd0, ld_ready0}, 32'd1);
      rst = 1'b0;
      count_clear("clr2");

      // Contents loaded earlier must now be zeroed.
      pc_in = 32'h4;
      step();
      chk("cleared_word", instruction, 32'h0);
      chk("cleared_valid", {31'd0, inst_valid}, 32'd1);
      pc_in = 32'h8;
      step();
      chk("cleared_word2", instruction, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
